// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg
// Shared definitions for the ENTER/LEAVE frame micro-sequencer:
//   - OP_ENTER / OP_LEAVE : encodings of the 'op' input
//   - STACK_WORD          : bytes moved per push/pop
//   - state_t             : sequencer state encoding
package frame_sequencer_pkg;

  localparam logic OP_ENTER = 1'b0;
  localparam logic OP_LEAVE = 1'b1;

  localparam logic [31:0] STACK_WORD = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCESS,
    COMMIT,
    DONE,
    FAULT
  } state_t;

endpackage

// File: rtl/frame_sequencer_ack_watchdog.sv
// frame_sequencer_ack_watchdog
// Counts cycles spent waiting for a memory acknowledge.
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous, active-low reset
//   clear   in  return the count to zero (has priority over enable)
//   enable  in  count this cycle
//   expired out count has reached ACK_TIMEOUT
module frame_sequencer_ack_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

  logic [CW-1:0] count;

  // Saturates at the limit so 'expired' stays asserted until cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Micro-sequencer for ENTER (level 0) and LEAVE. Snapshots ESP/EBP on start,
// performs one memory access over a req/ack handshake, then writes ESP and
// EBP together in a single commit cycle.
// Ports:
//   clock, reset           clock; asynchronous active-low reset
//   start, op, frame_size  decoder request (op: 0 = ENTER, 1 = LEAVE)
//   esp_in, ebp_in         current register values
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_rdata, mem_ack     memory response
//   esp_we/wdata           ESP write port (one-cycle strobe)
//   ebp_we/wdata           EBP write port (one-cycle strobe)
//   busy, done, fault      status: busy outside IDLE, one-cycle done/fault
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] frame_size,
  input  logic [31:0] esp_in,
  input  logic [31:0] ebp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        esp_we,
  output logic [31:0] esp_wdata,
  output logic        ebp_we,
  output logic [31:0] ebp_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  state_t      state, state_next;
  logic        op_q;
  logic [31:0] esp_q, ebp_q, fsz_q, rdata_q;
  logic [31:0] acc_addr;
  logic        wd_clear, wd_enable, wd_expired;

  // Snapshots are stable for the whole operation, so the access address can
  // be derived combinationally and reused unchanged from CHECK through ACCESS.
  assign acc_addr = (op_q == OP_LEAVE) ? ebp_q : (esp_q - STACK_WORD);

  assign wd_clear  = (state != ACCESS);
  assign wd_enable = (state == ACCESS) && !mem_ack;

  frame_sequencer_ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_ENTER;
      esp_q   <= '0;
      ebp_q   <= '0;
      fsz_q   <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        op_q  <= op;
        esp_q <= esp_in;
        ebp_q <= ebp_in;
        fsz_q <= {16'h0000, frame_size};
      end
      if ((state == ACCESS) && mem_ack && (op_q == OP_LEAVE)) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decode purely from state, so an asynchronous reset forces them
  // all low immediately, including a pending mem_req.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    esp_we     = 1'b0;
    esp_wdata  = '0;
    ebp_we     = 1'b0;
    ebp_wdata  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = CHECK;
        end
      end

      CHECK: begin
        busy = 1'b1;
        if (acc_addr[1:0] != 2'b00) begin
          state_next = FAULT;
        end else begin
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = acc_addr;
        if (op_q == OP_ENTER) begin
          mem_we    = 1'b1;
          mem_wdata = ebp_q;
        end
        // An ack arriving on the expiry cycle still completes the access.
        if (mem_ack) begin
          state_next = COMMIT;
        end else if (wd_expired) begin
          state_next = FAULT;
        end
      end

      COMMIT: begin
        busy   = 1'b1;
        esp_we = 1'b1;
        ebp_we = 1'b1;
        if (op_q == OP_ENTER) begin
          ebp_wdata = esp_q - STACK_WORD;
          esp_wdata = esp_q - STACK_WORD - fsz_q;
        end else begin
          esp_wdata = ebp_q + STACK_WORD;
          ebp_wdata = rdata_q;
        end
        state_next = DONE;
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      FAULT: begin
        busy       = 1'b1;
        fault      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
// Self-checking bench for frame_sequencer: a vector table of ENTER/LEAVE
// operations with hand-derived expected memory access, commit values,
// latency and request length, checked through an event scoreboard, plus a
// hand-written reset-during-access sequence.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] frame_size = 16'h0;
  logic [31:0] esp_in = 32'h0;
  logic [31:0] ebp_in = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, esp_we, ebp_we, busy, done, fault;
  logic [31:0] mem_addr, mem_wdata, esp_wdata, ebp_wdata;

  always #5 clock = ~clock;

  frame_sequencer #(.ACK_TIMEOUT(255)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .frame_size(frame_size),
    .esp_in    (esp_in),
    .ebp_in    (ebp_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .esp_we    (esp_we),
    .esp_wdata (esp_wdata),
    .ebp_we    (ebp_we),
    .ebp_wdata (ebp_wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;

  typedef enum int {EV_ACC, EV_COMMIT, EV_DONE, EV_FAULT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic        op;
    logic [31:0] esp;
    logic [31:0] ebp;
    logic [15:0] fsz;
    logic [31:0] rdata;
    int          waits;
    bit          ack_en;
    bit          inject;
    bit          exp_fault;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_esp;
    logic [31:0] exp_ebp;
    int          exp_lat;
    int          exp_req;
  } vec_t;
  vec_t vecs[10];

  // Memory responder: acks after 'ack_delay' wait states while enabled.
  bit          ack_en = 1'b0;
  int          ack_delay = 0;
  logic [31:0] rsp_data = 32'h0;
  int          wait_cnt = 0;

  always @(posedge clock) begin
    #1;
    mem_ack = 1'b0;
    if (!reset) begin
      wait_cnt = 0;
    end else if (mem_req && ack_en) begin
      if (wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rsp_data;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic takeEvent(input ev_kind_t k, input string na, input logic [31:0] a,
                           input string nb, input logic [31:0] b,
                           input string nc, input logic [31:0] c);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_event: got kind %0d, required no event", k);
      return;
    end
    e = sb.pop_front();
    checkOutput("event_kind", k, e.kind);
    if (k == e.kind) begin
      if (k == EV_ACC || k == EV_COMMIT) begin
        checkOutput(na, a, e.a);
        checkOutput(nb, b, e.b);
      end
      if (k == EV_ACC) begin
        checkOutput(nc, c, e.c);
      end
    end
  endtask

  // Scoreboard monitor: every observable DUT event must match the queue head.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_req) req_cnt++;
      if (mem_req && mem_ack)
        takeEvent(EV_ACC, "mem_addr", mem_addr, "mem_we", {31'b0, mem_we},
                  "mem_wdata", mem_wdata);
      if (esp_we || ebp_we) begin
        checkOutput("strobe_pair", {31'b0, esp_we}, {31'b0, ebp_we});
        takeEvent(EV_COMMIT, "esp_wdata", esp_wdata, "ebp_wdata", ebp_wdata, "", 32'h0);
      end
      if (done)  takeEvent(EV_DONE, "", 32'h0, "", 32'h0, "", 32'h0);
      if (fault) takeEvent(EV_FAULT, "", 32'h0, "", 32'h0, "", 32'h0);
    end
  end

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    bit fin;
    ev_t e;
    ack_en    = v.ack_en;
    ack_delay = v.waits;
    rsp_data  = v.rdata;
    req_cnt   = 0;
    if (v.exp_fault) begin
      e = '{EV_FAULT, 32'h0, 32'h0, 32'h0};
      sb.push_back(e);
    end else begin
      e = '{EV_ACC, v.exp_addr, {31'b0, v.exp_we}, v.exp_wdata};
      sb.push_back(e);
      e = '{EV_COMMIT, v.exp_esp, v.exp_ebp, 32'h0};
      sb.push_back(e);
      e = '{EV_DONE, 32'h0, 32'h0, 32'h0};
      sb.push_back(e);
    end
    @(posedge clock); #1;
    start = 1'b1; op = v.op; esp_in = v.esp; ebp_in = v.ebp; frame_size = v.fsz;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done || fault) begin
        fin = 1'b1;
        break;
      end
      @(posedge clock); #1;
      lat++;
      if (v.inject && lat == 2) begin
        start = 1'b1; op = OP_LEAVE; esp_in = 32'h5550; ebp_in = 32'h6660;
        frame_size = 16'h40;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s completion: got no done/fault, required one within 400 cycles", tag);
    end
    checkOutput({tag, " latency"}, lat, v.exp_lat);
    checkOutput({tag, " req_cycles"}, req_cnt, v.exp_req);
    repeat (3) @(negedge clock);
    checkOutput({tag, " scoreboard_left"}, sb.size(), 0);
    checkOutput({tag, " busy_after"}, {31'b0, busy}, 32'h0);
    sb.delete();
  endtask

  initial begin
    bit seen;
    //            op    esp            ebp            fsz       rdata          w    ack  inj  flt  addr           we    wdata          esp            ebp            lat  req
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0000_0999, 16'h0010, 32'h0,          0, 1'b1,1'b0,1'b0, 32'h0000_0FFC, 1'b1, 32'h0000_0999, 32'h0000_0FEC, 32'h0000_0FFC,   4,   1};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'h0000_0FFC, 16'h0000, 32'h0000_0999,  3, 1'b1,1'b0,1'b0, 32'h0000_0FFC, 1'b0, 32'h0,          32'h0000_1000, 32'h0000_0999,   7,   4};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'h0000_0FFE, 16'h0000, 32'h0,          0, 1'b1,1'b0,1'b1, 32'h0,          1'b0, 32'h0,          32'h0,          32'h0,            2,   0};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_1234, 16'h0008, 32'h0,          1, 1'b1,1'b0,1'b0, 32'h0000_0000, 1'b1, 32'h0000_1234, 32'hFFFF_FFF8, 32'h0000_0000,   5,   2};
    vecs[4] = '{1'b0, 32'h0000_1002, 32'h0000_0005, 16'h0004, 32'h0,          0, 1'b1,1'b0,1'b1, 32'h0,          1'b0, 32'h0,          32'h0,          32'h0,            2,   0};
    vecs[5] = '{1'b0, 32'h0002_0000, 32'hAAAA_5555, 16'hFFFF, 32'h0,          2, 1'b1,1'b0,1'b0, 32'h0001_FFFC, 1'b1, 32'hAAAA_5555, 32'h0000_FFFD, 32'h0001_FFFC,   6,   3};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 16'h0000, 32'hDEAD_BEEC,  0, 1'b1,1'b0,1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,          32'h0000_0000, 32'hDEAD_BEEC,   4,   1};
    vecs[7] = '{1'b0, 32'h0000_8000, 32'h0000_7000, 16'h0020, 32'h0,          1, 1'b1,1'b1,1'b0, 32'h0000_7FFC, 1'b1, 32'h0000_7000, 32'h0000_7FDC, 32'h0000_7FFC,   5,   2};
    vecs[8] = '{1'b0, 32'h0000_3000, 32'h0000_0100, 16'h0000, 32'h0,          0, 1'b0,1'b0,1'b1, 32'h0,          1'b0, 32'h0,          32'h0,          32'h0,          258, 256};
    vecs[9] = '{1'b0, 32'h0000_3000, 32'h0000_0100, 16'h0004, 32'h0,        255, 1'b1,1'b0,1'b0, 32'h0000_2FFC, 1'b1, 32'h0000_0100, 32'h0000_2FF8, 32'h0000_2FFC, 259, 256};

    #12;
    checkOutput("reset_ctrl", {25'b0, mem_req, mem_we, esp_we, ebp_we, busy, done, fault}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_esp_wdata", esp_wdata, 32'h0);
    checkOutput("reset_ebp_wdata", ebp_wdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while an ENTER is waiting for its ack.
    ack_en = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    start = 1'b1; op = OP_ENTER; esp_in = 32'h4000; ebp_in = 32'h1; frame_size = 16'h0;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rst_req_seen", {31'b0, seen}, 32'h1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_strobes", {30'b0, esp_we, ebp_we}, 32'h0);
    @(negedge clock);
    checkOutput("rst_status", {29'b0, busy, done, fault}, 32'h0);
    @(posedge clock); #2;
    reset = 1'b1;
    applyStimulus(vecs[0], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
